// File: rtl/mul_arb_pkg.sv
// Shared widths and FSM state encoding for the mul_arbiter slice.
// PIPE is always declared so both builds (with/without MUL_ARB_PIPE_EN) share one enum.
package mul_arb_pkg;

  localparam int unsigned OPW = 256;
  localparam int unsigned PW  = 512;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    PIPE,
    RESP
  } mul_arb_state_t;

endpackage

// File: rtl/ks256.sv
// Combinational 256x256 -> 512 unsigned multiplier, one Karatsuba level over 128-bit halves.
module ks256 (
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [511:0] p
);

  logic [127:0] a0, a1, b0, b1;
  logic [128:0] sa, sb;
  logic [255:0] z0, z2;
  logic [257:0] zm, z1;

  assign a0 = a[127:0];
  assign a1 = a[255:128];
  assign b0 = b[127:0];
  assign b1 = b[255:128];

  assign sa = {1'b0, a1} + {1'b0, a0};
  assign sb = {1'b0, b1} + {1'b0, b0};

  assign z0 = a0 * b0;
  assign z2 = a1 * b1;
  assign zm = sa * sb;

  // Cross term a1*b0 + a0*b1 recovered from the middle product; never negative.
  assign z1 = zm - {2'b00, z0} - {2'b00, z2};

  assign p = {z2, z0} + ({254'b0, z1} << 128);

endmodule

// File: rtl/mul_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one ks256 among NREQ requesters, registered in and out.
// Define MUL_ARB_PIPE_EN to add a second result register stage (latency 3, interval 4).
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*256-1:0] req_a,
  input  logic [NREQ*256-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [511:0]        rsp_prod
);

  mul_arb_state_t state, state_next;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  rr_ptr;
  logic [OPW-1:0]  op_a, op_b;
  logic [IDW-1:0]  op_id, id_q;
  logic [PW-1:0]   mul_p, prod_q;
  logic            rsp_valid_q;
  logic            accept;
`ifdef MUL_ARB_PIPE_EN
  logic [PW-1:0]   prod_p;
`endif

  rr_arbiter #(
    .N (NREQ),
    .IW(IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  ks256 u_ks (
    .a(op_a),
    .b(op_b),
    .p(mul_p)
  );

  // Grant only ever shown while idle and out of reset, so nothing looks accepted under rst.
  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = ((state == IDLE) && !rst) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (|req_valid) state_next = MUL;
`ifdef MUL_ARB_PIPE_EN
      MUL:  state_next = PIPE;
`else
      MUL:  state_next = RESP;
`endif
      PIPE: state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      prod_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
`ifdef MUL_ARB_PIPE_EN
      prod_p      <= '0;
`endif
    end else begin
      if (accept) begin
        op_a   <= req_a[gnt_id*OPW +: OPW];
        op_b   <= req_b[gnt_id*OPW +: OPW];
        op_id  <= gnt_id;
        rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
      if (state == MUL) begin
        prod_q <= mul_p;
        id_q   <= op_id;
      end
`ifdef MUL_ARB_PIPE_EN
      if (state == PIPE) prod_p <= prod_q;
`endif
      rsp_valid_q <= (state_next == RESP);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
`ifdef MUL_ARB_PIPE_EN
  assign rsp_prod  = prod_p;
`else
  assign rsp_prod  = prod_q;
`endif

endmodule
